bundle_request_arbiter: RTL and testbench

BUNDLE_REQUEST_ARBITER -- requirements
Module: bundle_request_arbiter

---
 rtl/bundle_request_arbiter_pkg.sv | 26 ++
 rtl/bundle_request_arbiter_rr_priority_select.sv | 37 +++
 rtl/bundle_request_arbiter.sv | 125 ++++++++++++
 tb/tb_bundle_request_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bundle_request_arbiter_pkg.sv
// rtl/bundle_request_arbiter_pkg.sv - global widths, packet layout and arbiter state shared by the arbiter slice
package bundle_request_arbiter_pkg;

  localparam int CU_BUNDLE_COUNT        = 4;
  localparam int GLOBAL_ADDR_WIDTH_BITS = 64;
  localparam int GLOBAL_DATA_WIDTH_BITS = 32;

  // Flattened on the ports as {addr, data, is_write, last}; last sits in bit 0.
  typedef struct packed {
    logic [GLOBAL_ADDR_WIDTH_BITS-1:0] addr;
    logic [GLOBAL_DATA_WIDTH_BITS-1:0] data;
    logic                              is_write;
    logic                              last;
  } req_pkt_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bundle_request_arbiter_rr_priority_select.sv
// rtl/bundle_request_arbiter_rr_priority_select.sv - first active request at or after the pointer, wrapping
module rr_priority_select
  import bundle_request_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CU_BUNDLE_COUNT,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int unsigned      base;
  int unsigned      idx;
  logic [IDX_W-1:0] idx_n;
  logic             found;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    base      = 32'(ptr);
    idx       = 0;
    idx_n     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (base + 32'(k)) % 32'(NUM_REQ);
      idx_n = IDX_W'(idx);
      if (!found && req[idx_n]) begin
        found     = 1'b1;
        grant_idx = idx_n;
      end
    end
    grant_valid = found;
  end

endmodule

// File: rtl/bundle_request_arbiter.sv
// rtl/bundle_request_arbiter.sv - round-robin, burst-locking request arbiter with one registered output stage
module bundle_request_arbiter
  import bundle_request_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = CU_BUNDLE_COUNT,
  parameter  int ADDR_W  = GLOBAL_ADDR_WIDTH_BITS,
  parameter  int DATA_W  = GLOBAL_DATA_WIDTH_BITS,
  localparam int PKT_W   = ADDR_W + DATA_W + 2,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic [NUM_REQ-1:0][PKT_W-1:0] in_pkt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PKT_W-1:0]              out_pkt,
  output logic [IDX_W-1:0]              out_id
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             out_valid_q, out_valid_d;
  logic [PKT_W-1:0] out_pkt_q, out_pkt_d;
  logic [IDX_W-1:0] out_id_q, out_id_d;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_live;
  logic             can_accept;
  logic             accept;
  logic [PKT_W-1:0] grant_pkt;
  logic             beat_last;
  logic [IDX_W-1:0] next_ptr;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_sel (
    .req         (in_valid),
    .ptr         (rr_ptr_q),
    .grant_idx   (sel_idx),
    .grant_valid (sel_valid)
  );

  // Grant: round-robin pick when idle, the burst owner while locked.
  always_comb begin
    grant_idx  = sel_idx;
    grant_live = sel_valid;
    if (state_q == ARB_LOCKED) begin
      grant_idx  = lock_idx_q;
      grant_live = 1'b1;
    end
  end

  // Ready goes to the grantee only when the output register can take a beat.
  always_comb begin
    in_ready   = '0;
    can_accept = !out_valid_q || out_ready;
    if (!areset && grant_live && can_accept) begin
      in_ready[grant_idx] = 1'b1;
    end
    accept    = |(in_valid & in_ready);
    grant_pkt = in_pkt[grant_idx];
    beat_last = grant_pkt[0];
    next_ptr  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  // Lock on a non-final beat, release and advance the pointer on the final one.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      if (beat_last) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = next_ptr;
      end else begin
        state_d    = ARB_LOCKED;
        lock_idx_d = grant_idx;
      end
    end
  end

  // Output register: load on accept, otherwise empty once drained.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pkt_d   = out_pkt_q;
    out_id_d    = out_id_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_pkt_d   = grant_pkt;
      out_id_d    = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output flops; reset drops any lock and any pending beat.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      lock_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_idx_q  <= lock_idx_d;
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pkt   = out_pkt_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_bundle_request_arbiter.sv
// tb/tb_bundle_request_arbiter.sv - self-checking bench for bundle_request_arbiter
module tb_bundle_request_arbiter;
  import bundle_request_arbiter_pkg::*;

  localparam int N  = CU_BUNDLE_COUNT;
  localparam int PW = GLOBAL_ADDR_WIDTH_BITS + GLOBAL_DATA_WIDTH_BITS + 2;
  localparam int IW = $clog2(N);

  logic                   ap_clk = 1'b0;
  logic                   areset;
  logic [N-1:0]           in_valid;
  logic [N-1:0]           in_ready;
  logic [N-1:0][PW-1:0]   in_pkt;
  logic                   out_valid;
  logic                   out_ready;
  logic [PW-1:0]          out_pkt;
  logic [IW-1:0]          out_id;

  always #5 ap_clk = ~ap_clk;

  bundle_request_arbiter dut (
    .ap_clk    (ap_clk),
    .areset    (areset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pkt    (in_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt),
    .out_id    (out_id)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit            m_locked;
  int            m_lock_idx;
  int            m_ptr;
  bit            m_ov;
  logic [PW-1:0] m_pkt;
  int            m_id;
  int            exp_g;
  bit            exp_acc;
  int            rem [N];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval();
    exp_g   = -1;
    exp_acc = 1'b0;
    if (areset) return;
    if (m_locked) exp_g = m_lock_idx;
    else begin
      for (int k = 0; k < N; k++) begin
        if (exp_g < 0 && in_valid[(m_ptr + k) % N]) exp_g = (m_ptr + k) % N;
      end
    end
    if (exp_g >= 0) exp_acc = in_valid[exp_g] && (!m_ov || out_ready);
  endfunction

  function automatic void model_update();
    if (areset) begin
      m_locked = 1'b0; m_lock_idx = 0; m_ptr = 0; m_ov = 1'b0; m_pkt = '0; m_id = 0;
    end else if (exp_acc) begin
      m_ov  = 1'b1;
      m_pkt = in_pkt[exp_g];
      m_id  = exp_g;
      if (in_pkt[exp_g][0]) begin
        m_locked = 1'b0;
        m_ptr    = (exp_g + 1) % N;
      end else begin
        m_locked   = 1'b1;
        m_lock_idx = exp_g;
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [N-1:0] acc_vec;
    logic [N-1:0] others;
    @(negedge ap_clk);
    model_eval();
    acc_vec = '0;
    if (exp_acc) acc_vec[exp_g] = 1'b1;
    chk("accept_vec", in_valid & in_ready, acc_vec);
    if (areset || (m_ov && !out_ready) || exp_g < 0) chk("ready_zero", in_ready, 0);
    else begin
      others = in_ready;
      others[exp_g] = 1'b0;
      chk("ready_onehot", others, 0);
    end
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_pkt", out_pkt, m_pkt);
      chk("out_id", out_id, m_id);
    end
    @(posedge ap_clk);
    model_update();
    #1;
  endtask

  function automatic logic [PW-1:0] mk_pkt(input int i, input bit last);
    req_pkt_t p;
    p.addr     = 64'h100 + 64'(i);
    p.data     = 32'(i);
    p.is_write = 1'b0;
    p.last     = last;
    return p;
  endfunction

  task automatic set_single(input logic [N-1:0] v);
    in_valid = v;
    for (int i = 0; i < N; i++) in_pkt[i] = mk_pkt(i, 1'b1);
  endtask

  task automatic do_reset();
    areset    = 1'b1;
    in_valid  = '0;
    out_ready = 1'b1;
    step();
    step();
    areset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pkt", out_pkt, 0);
    chk("rst_out_id", out_id, 0);
  endtask

  task automatic drive_random();
    req_pkt_t p;
    areset    = ($urandom_range(0, 199) == 0);
    out_ready = ($urandom_range(0, 99) < 70);
    for (int i = 0; i < N; i++) begin
      in_valid[i] = ($urandom_range(0, 99) < 55);
      p.addr      = {$urandom, $urandom};
      p.data      = $urandom;
      p.is_write  = 1'($urandom_range(0, 1));
      p.last      = (rem[i] == 1);
      in_pkt[i]   = p;
    end
  endtask

  initial begin
    int       seq [5];
    req_pkt_t lit;
    logic [PW-1:0] held;
    seq = '{0, 1, 2, 3, 0};
    areset = 1'b1; in_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_pkt[i] = '0;
    m_locked = 0; m_lock_idx = 0; m_ptr = 0; m_ov = 0; m_pkt = '0; m_id = 0;
    exp_g = -1; exp_acc = 0;

    // All requesters, single beats: strict rotation
    do_reset();
    set_single('1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rot_valid", out_valid, 1);
      chk("rot_id", out_id, seq[k]);
    end

    // Downstream stall holds the beat and blocks inputs, then flow resumes
    out_ready = 1'b0;
    held = mk_pkt(0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_id", out_id, 0);
      chk("stall_pkt", out_pkt, held);
      chk("stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("resume_valid", out_valid, 1);
      chk("resume_id", out_id, k % N);
    end

    // Burst from requester 2 keeps the grant while others wait
    do_reset();
    set_single(4'b0011);
    step(); chk("pre_id0", out_id, 0);
    step(); chk("pre_id1", out_id, 1);
    in_valid = '1;
    for (int b = 0; b < 3; b++) begin
      in_pkt[2] = mk_pkt(2, b == 2);
      step();
      chk("burst_id", out_id, 2);
    end
    step(); chk("after_burst_id3", out_id, 3);
    step(); chk("after_burst_id0", out_id, 0);

    // Pointer wrap from 3 back to 0
    do_reset();
    set_single(4'b0100);
    step(); chk("wrap_pre", out_id, 2);
    set_single(4'b1000);
    step(); chk("wrap_id3", out_id, 3);
    set_single(4'b1111);
    step(); chk("wrap_id0", out_id, 0);

    // Reset while locked with a pending beat
    do_reset();
    in_valid  = 4'b0001;
    in_pkt[0] = mk_pkt(0, 1'b0);
    out_ready = 1'b0;
    step();
    chk("lock_valid", out_valid, 1);
    chk("lock_id", out_id, 0);
    areset = 1'b1;
    step();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_id", out_id, 0);
    areset = 1'b0;
    set_single(4'b0010);
    out_ready = 1'b1;
    step();
    chk("postrst_valid", out_valid, 1);
    chk("postrst_id", out_id, 1);

    // Exact packet pass-through, then drain
    do_reset();
    lit.addr = 64'h0000_0000_DEAD_BEE0;
    lit.data = 32'hCAFE_F00D;
    lit.is_write = 1'b1;
    lit.last = 1'b1;
    in_valid = 4'b0010;
    in_pkt[1] = lit;
    step();
    chk("lit_pkt", out_pkt, lit);
    chk("lit_id", out_id, 1);
    in_valid = '0;
    step();
    chk("drain_valid", out_valid, 0);

    // Randomized traffic with bursts of 1..4 beats
    for (int i = 0; i < N; i++) rem[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      step();
      if (exp_acc) begin
        rem[exp_g]--;
        if (rem[exp_g] == 0) rem[exp_g] = $urandom_range(1, 4);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
